// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages carrying WIDTH-bit tokens,
// with bubble collapse, synchronous reset/preset/flush and a live token count.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
  parameter int               CNT_W   = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] emit;
  logic [DEPTH-1:0] recv;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             ctl;
  logic             in_xfer;
  logic             out_xfer;

  // Any control pulse freezes both handshakes so no token moves that cycle.
  assign ctl      = rst_i | set_i | flush_i;
  assign valid_o  = vld[DEPTH-1] & ~ctl;
  assign out_xfer = valid_o & ready_i;
  assign ready_o  = acc[0] & ~ctl;
  assign in_xfer  = valid_i & ready_o;
  assign q_o      = data[DEPTH-1];
  assign count_o  = count;

  // Ready chain, walked from the output back towards the input.
  always_comb begin
    emit = '0;
    acc  = '0;
    emit[DEPTH-1] = out_xfer;
    acc[DEPTH-1]  = ~vld[DEPTH-1] | out_xfer;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      emit[k] = vld[k] & acc[k+1];
      acc[k]  = ~vld[k] | emit[k];
    end
  end

  always_comb begin
    recv    = '0;
    recv[0] = in_xfer;
    for (int k = 1; k < DEPTH; k++) begin
      recv[k] = emit[k-1];
    end
    vld_nxt   = recv | (vld & ~emit);
    count_nxt = count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

  // Register stage update: data of empty or stalled stages simply holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= RST_VAL;
      end
      vld   <= '0;
      count <= '0;
    end else if (set_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= SET_VAL;
      end
      vld   <= '1;
      count <= CNT_W'(DEPTH);
    end else if (flush_i) begin
      vld   <= '0;
      count <= '0;
    end else begin
      if (recv[0]) begin
        data[0] <= d_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (recv[k]) begin
          data[k] <= data[k-1];
        end
      end
      vld   <= vld_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=8, DEPTH=3): inputs change on the negedge,
// outputs are checked 1 unit later, well away from the rising edge.
module tb_dff_pipe;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       set_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] d_i = 8'h00;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [7:0] q_o;
  logic [1:0] count_o;

  int checks = 0;
  int failures = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_i   (set_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .d_i     (d_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .q_o     (q_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f,
                      input logic vi, input logic [7:0] d, input logic ri);
    @(negedge clk_i);
    rst_i   = r;
    set_i   = s;
    flush_i = f;
    valid_i = vi;
    d_i     = d;
    ready_i = ri;
    #1;
  endtask

  initial begin
    // 1. Reset
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("rst_q", q_o, 8'h00);
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ready", ready_o, 1);

    // 2. Streaming AA,55,0F with ready_i=1
    step(0, 0, 0, 1, 8'hAA, 1);
    chk("st_ready0", ready_o, 1);
    step(0, 0, 0, 1, 8'h55, 1);
    chk("st_count1", count_o, 1);
    chk("st_valid1", valid_o, 0);
    step(0, 0, 0, 1, 8'h0F, 1);
    chk("st_count2", count_o, 2);
    chk("st_valid2", valid_o, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("st_valid3", valid_o, 1);
    chk("st_qAA", q_o, 8'hAA);
    chk("st_count3", count_o, 3);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("st_q55", q_o, 8'h55);
    chk("st_count_d2", count_o, 2);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("st_q0F", q_o, 8'h0F);
    chk("st_count_d1", count_o, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("st_empty_valid", valid_o, 0);
    chk("st_empty_count", count_o, 0);

    // Reset raised mid-period: q_o keeps its value until the next rising edge
    step(1, 0, 0, 0, 8'h00, 1);
    chk("midrst_q_hold", q_o, 8'h0F);
    chk("midrst_ready_gated", ready_o, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("midrst_q_after", q_o, 8'h00);
    chk("midrst_count", count_o, 0);

    // 3. Backpressure: 11,22,33 fill the pipe, 44 waits
    step(0, 0, 0, 1, 8'h11, 0);
    chk("bp_ready_a", ready_o, 1);
    step(0, 0, 0, 1, 8'h22, 0);
    chk("bp_ready_b", ready_o, 1);
    step(0, 0, 0, 1, 8'h33, 0);
    chk("bp_ready_c", ready_o, 1);
    step(0, 0, 0, 1, 8'h44, 0);
    chk("bp_full_ready", ready_o, 0);
    chk("bp_full_count", count_o, 3);
    chk("bp_full_q", q_o, 8'h11);
    step(0, 0, 0, 1, 8'h44, 0);
    chk("bp_hold_ready", ready_o, 0);
    chk("bp_hold_q", q_o, 8'h11);
    chk("bp_hold_count", count_o, 3);
    step(0, 0, 0, 1, 8'h44, 1);
    chk("bp_pushpop_ready", ready_o, 1);
    chk("bp_pushpop_q", q_o, 8'h11);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bp_q22", q_o, 8'h22);
    chk("bp_count_after", count_o, 3);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bp_q33", q_o, 8'h33);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bp_q44", q_o, 8'h44);
    chk("bp_valid44", valid_o, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bp_drained", count_o, 0);

    // 4. Bubble collapse: 5A, two idle cycles, A5, all with ready_i=0
    step(0, 0, 0, 1, 8'h5A, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 1, 8'hA5, 0);
    chk("bc_q5A_early", q_o, 8'h5A);
    chk("bc_count1", count_o, 1);
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bc_count2", count_o, 2);
    chk("bc_q5A", q_o, 8'h5A);
    chk("bc_valid5A", valid_o, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bc_qA5", q_o, 8'hA5);
    chk("bc_validA5", valid_o, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("bc_empty", valid_o, 0);

    // 5. Preset drops the concurrent input token
    step(0, 1, 0, 1, 8'h77, 0);
    chk("set_ready_gated", ready_o, 0);
    chk("set_valid_gated", valid_o, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    chk("set_valid", valid_o, 1);
    chk("set_q", q_o, 8'hFF);
    chk("set_count", count_o, 3);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("set_pop1", q_o, 8'hFF);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("set_pop2", q_o, 8'hFF);
    chk("set_cnt2", count_o, 2);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("set_pop3", q_o, 8'hFF);
    chk("set_cnt1", count_o, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("set_drained", count_o, 0);
    chk("set_drained_valid", valid_o, 0);

    // 6. Flush with preset: preset wins, then a lone flush empties the pipe
    step(0, 0, 0, 1, 8'h01, 0);
    step(0, 0, 0, 1, 8'h02, 0);
    step(0, 0, 0, 1, 8'h03, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    chk("fl_pre_count", count_o, 3);
    chk("fl_pre_q", q_o, 8'h01);
    step(0, 1, 1, 0, 8'h00, 0);
    step(0, 0, 1, 0, 8'h00, 0);
    chk("fl_setwins_count", count_o, 3);
    chk("fl_setwins_q", q_o, 8'hFF);
    step(0, 0, 0, 0, 8'h00, 0);
    chk("fl_count", count_o, 0);
    chk("fl_valid", valid_o, 0);
    chk("fl_q_hold", q_o, 8'hFF);
    chk("fl_ready", ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
